// File: rtl/comparator_pkg.sv
// Shared comparator types: operand width, six-flag result struct and the arbiter FSM states.
package comparator_pkg;

    parameter int unsigned WIDTH = 8;

    typedef struct packed {
        logic eq;
        logic ne;
        logic gt;
        logic lt;
        logic ge;
        logic le;
    } cmp_flags_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_RSP
    } cmp_arb_state_e;

endpackage

// File: rtl/comparator.sv
// Combinational magnitude comparator producing {eq,ne,gt,lt,ge,le}; i_signed selects two's complement.
module comparator
    import comparator_pkg::*;
(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed,
    output cmp_flags_t       o_flags
);

    logic w_eq;
    logic w_lt;
    logic w_gt;

    always_comb begin
        w_eq = (i_a == i_b);
        if (i_signed) begin
            w_lt = ($signed(i_a) < $signed(i_b));
            w_gt = ($signed(i_a) > $signed(i_b));
        end else begin
            w_lt = (i_a < i_b);
            w_gt = (i_a > i_b);
        end
        o_flags.eq = w_eq;
        o_flags.ne = ~w_eq;
        o_flags.gt = w_gt;
        o_flags.lt = w_lt;
        o_flags.ge = ~w_lt;
        o_flags.le = ~w_gt;
    end

endmodule

// File: rtl/cmp_rr_arbiter.sv
// Round-robin arbiter sharing one comparator among N_REQ requesters.
// Optional macro CMP_ARB_STATS_EN adds per-requester 16-bit saturating op counters (op_count_o).
module cmp_rr_arbiter
    import comparator_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] req_a_i,
    input  logic [N_REQ*WIDTH-1:0] req_b_i,
    input  logic [N_REQ-1:0]       req_signed_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [IDW-1:0]         rsp_id_o,
    output cmp_flags_t             rsp_flags_o,
    output logic                   busy_o
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]    op_count_o
`endif
);

    // First valid index at or above ptr, wrapping around.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [IDW-1:0]   ptr);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        logic           found;
        int unsigned    s;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            s   = ({{(32-IDW){1'b0}}, ptr} + i) % N_REQ;
            idx = s[IDW-1:0];
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    cmp_arb_state_e   r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_gnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [IDW-1:0]   r_rsp_id;
    cmp_flags_t       r_rsp_flags;

    logic [WIDTH-1:0] w_a [N_REQ];
    logic [WIDTH-1:0] w_b [N_REQ];
    logic [IDW-1:0]   w_pick;
    cmp_flags_t       w_flags;
    logic             w_rsp_hs;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign w_a[k] = req_a_i[k*WIDTH +: WIDTH];
        assign w_b[k] = req_b_i[k*WIDTH +: WIDTH];
    end

    assign w_pick   = rr_pick(req_valid_i, r_ptr);
    assign w_rsp_hs = (r_state == S_RSP) && rsp_ready_i;

    // Grant is a same-cycle pulse; masked by rst_i so outputs read zero during reset.
    always_comb begin
        req_ready_o = '0;
        if ((r_state == S_IDLE) && !rst_i && (|req_valid_i)) begin
            req_ready_o[w_pick] = 1'b1;
        end
    end

    comparator u_comparator (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_signed (r_signed),
        .o_flags  (w_flags)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_signed    <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_flags <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (|req_valid_i) begin
                        r_gnt    <= w_pick;
                        r_a      <= w_a[w_pick];
                        r_b      <= w_b[w_pick];
                        r_signed <= req_signed_i[w_pick];
                        r_state  <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_rsp_flags <= w_flags;
                    r_rsp_id    <= r_gnt;
                    r_state     <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready_i) begin
                        r_ptr   <= (r_gnt == IDW'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid_o = (r_state == S_RSP);
    assign rsp_id_o    = r_rsp_id;
    assign rsp_flags_o = r_rsp_flags;
    assign busy_o      = (r_state != S_IDLE);

`ifdef CMP_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] r_op_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op_cnt <= '0;
        end else if (w_rsp_hs) begin
            for (int k = 0; k < N_REQ; k++) begin
                if ((r_gnt == IDW'(k)) && (r_op_cnt[k] != 16'hFFFF)) begin
                    r_op_cnt[k] <= r_op_cnt[k] + 16'd1;
                end
            end
        end
    end

    assign op_count_o = r_op_cnt;
`else
    logic w_unused_hs;
    assign w_unused_hs = w_rsp_hs;
`endif

endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// Directed bench for cmp_rr_arbiter: vector table plus fairness, backpressure and reset sequences.
module tb_cmp_rr_arbiter;
    import comparator_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_signed;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    cmp_flags_t  rsp_flags;
    logic        busy;
`ifdef CMP_ARB_STATS_EN
    logic [63:0] op_count;
`endif

    cmp_rr_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_signed_i (req_signed),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_flags_o  (rsp_flags),
        .busy_o       (busy)
`ifdef CMP_ARB_STATS_EN
        ,
        .op_count_o   (op_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sgn;
        logic [1:0]  exp_id;
        logic [5:0]  exp_flags;
    } vec_t;

    // One full transaction from S_IDLE with rsp_ready held high.
    task automatic run_op(input string name, input logic [3:0] valid, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] sgn, input logic [1:0] id,
                          input logic [5:0] flags);
        req_valid  = valid;
        req_a      = a;
        req_b      = b;
        req_signed = sgn;
        rsp_ready  = 1'b1;
        @(negedge clk);
        check({name, " grant"}, 64'(req_ready), 64'(4'b0001 << id));
        tick();
        req_valid = '0;
        @(negedge clk);
        check({name, " cmp"}, {59'd0, rsp_valid, busy, req_ready}, {59'd0, 1'b0, 1'b1, 4'b0000});
        tick();
        @(negedge clk);
        check({name, " rsp"}, {55'd0, rsp_valid, rsp_id, rsp_flags}, {55'd0, 1'b1, id, flags});
        tick();
    endtask

    vec_t vecs [7];

    initial begin
        // flags order {eq,ne,gt,lt,ge,le}
        vecs[0] = '{4'b0001, 32'h0000_002D, 32'h0000_002D, 4'b0001, 2'd0, 6'b100011};
        vecs[1] = '{4'b0010, 32'h0000_D300, 32'h0000_2D00, 4'b0010, 2'd1, 6'b010101};
        vecs[2] = '{4'b0010, 32'h0000_D300, 32'h0000_2D00, 4'b0000, 2'd1, 6'b011010};
        vecs[3] = '{4'b1001, 32'h8000_0000, 32'h7F00_0000, 4'b1000, 2'd3, 6'b010101};
        vecs[4] = '{4'b1001, 32'h0000_00FF, 32'h0000_0001, 4'b0000, 2'd0, 6'b011010};
        vecs[5] = '{4'b0101, 32'h0000_0000, 32'h0000_0000, 4'b0000, 2'd2, 6'b100011};
        vecs[6] = '{4'b0001, 32'h0000_007F, 32'h0000_0080, 4'b0001, 2'd0, 6'b011010};

        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_signed = '0;
        rsp_ready  = 1'b0;
        tick();
        @(negedge clk);
        check("reset state", {53'd0, req_ready, rsp_valid, rsp_id, rsp_flags, busy}, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].sgn,
                   vecs[i].exp_id, vecs[i].exp_flags);
        end

        // Fairness: all requesters valid from a fresh reset, one op every 3 cycles.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        req_valid  = 4'b1111;
        req_a      = 32'h1111_1111;
        req_b      = 32'h1111_1111;
        req_signed = 4'b0000;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("fair grant%0d", i), 64'(req_ready), 64'(4'b0001 << (i % 4)));
            tick();
            tick();
            @(negedge clk);
            check($sformatf("fair rsp%0d", i), {61'd0, rsp_valid, rsp_id},
                  {61'd0, 1'b1, 2'(i % 4)});
            tick();
        end
        req_valid = '0;

        // Backpressure: rr_ptr is 1, so req1 wins; other requests appear while held.
        req_valid  = 4'b0010;
        req_a      = 32'h0000_D300;
        req_b      = 32'h0000_2D00;
        req_signed = 4'b0010;
        rsp_ready  = 1'b0;
        @(negedge clk);
        check("bp grant", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = 4'b1111;
        req_a     = 32'hFFFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("bp hold%0d", c), {51'd0, rsp_valid, rsp_id, rsp_flags, req_ready},
                  {51'd0, 1'b1, 2'd1, 6'b010101, 4'b0000});
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();

        // Reset mid-op: rr_ptr is 2, req1 still wins by wrap; reset hits in S_CMP.
        req_valid = 4'b0010;
        req_a     = 32'h0000_D300;
        @(negedge clk);
        check("rst grant", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = 4'b0100;
        #2;
        rst = 1'b1;
        #1;
        check("rst async", {53'd0, req_ready, rsp_valid, rsp_id, rsp_flags, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst req2 grant", 64'(req_ready), 64'(4'b0100));
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        check("rst req2 rsp", {61'd0, rsp_valid, rsp_id}, {61'd0, 1'b1, 2'd2});
        tick();

        // rr_ptr is now 3; reset must clear it so requester 0 wins next.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        check("rst ptr clear", 64'(req_ready), 64'(4'b0001));
        tick();
        req_valid = '0;
        tick();
        tick();

`ifdef CMP_ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_op($sformatf("stat%0d", i), 4'b1000, 32'h0500_0000, 32'h0300_0000, 4'b0000,
                   2'd3, 6'b011010);
        end
        check("stat count3", op_count, {16'd3, 48'd0});
        force dut.r_op_cnt[3] = 16'hFFFF;
        #1;
        release dut.r_op_cnt[3];
        run_op("stat sat", 4'b1000, 32'h0500_0000, 32'h0300_0000, 4'b0000, 2'd3, 6'b011010);
        check("stat saturate", op_count, {16'hFFFF, 48'd0});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
